// File: rtl/riscv_pkg.sv
// Shared RV32 writeback encodings: the writeback source select, the load funct3 codes
// and the default datapath width.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_RSVD = 2'b11;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Picks the byte, halfword or word out of an aligned memory word and sign- or zero-extends it.
// A misaligned access or an unknown funct3 raises fault and forces data to zero.
module load_extend #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            fault
);
  import riscv_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
    data     = '0;
    fault    = 1'b0;
    case (funct3)
      LOAD_F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LOAD_F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_F3_LH: begin
        data  = {{(XLEN-16){half_sel[15]}}, half_sel};
        fault = offset[0];
      end
      LOAD_F3_LHU: begin
        data  = {{(XLEN-16){1'b0}}, half_sel};
        fault = offset[0];
      end
      LOAD_F3_LW: begin
        data  = raw;
        fault = (offset != 2'b00);
      end
      default: fault = 1'b1;
    endcase
    if (fault) data = '0;
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register followed by the writeback mux, the load fault detector and the
// retired-instruction counter.
module writeback_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus4,
  output logic             RegWrite,
  output logic [4:0]       WR,
  output logic [XLEN-1:0]  WD,
  output logic             wb_valid,
  output logic             load_fault,
  output logic [CNT_W-1:0] instret
);
  import riscv_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Handshake: in_valid qualifies every in_* field and has no ready. An instruction is taken
  // at a posedge with rst=0, flush=0, stall=0. The held instruction retires at a posedge with
  // stall=0 or flush=1, and a flush throws away the incoming instruction, not the held one.
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic [1:0]      wb_sel_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] mem_rdata_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic [XLEN-1:0] ext_data;
  logic            ext_fault;
  logic            retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      wb_sel_q     <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_plus4_q   <= '0;
      instret      <= '0;
    end else begin
      if (retire) instret <= instret + CNT_ONE;
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (!stall) begin
        wb_valid     <= in_valid;
        reg_write_q  <= in_reg_write;
        rd_q         <= in_rd;
        wb_sel_q     <= in_wb_sel;
        funct3_q     <= in_funct3;
        alu_result_q <= in_alu_result;
        mem_rdata_q  <= in_mem_rdata;
        pc_plus4_q   <= in_pc_plus4;
      end
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw    (mem_rdata_q),
    .offset (alu_result_q[1:0]),
    .funct3 (funct3_q),
    .data   (ext_data),
    .fault  (ext_fault)
  );

  // A stalled instruction keeps driving the register-file write; the counter waits for it to leave.
  assign load_fault = wb_valid && (wb_sel_q == WB_SEL_LOAD) && ext_fault;
  assign retire     = wb_valid && !load_fault && (!stall || flush);
  assign RegWrite   = wb_valid && reg_write_q && (rd_q != 5'd0) && !load_fault;
  assign WR         = rd_q;

  always_comb begin
    WD = alu_result_q;
    case (wb_sel_q)
      WB_SEL_LOAD: WD = ext_data;
      WB_SEL_PC4:  WD = pc_plus4_q;
      default:     WD = alu_result_q;
    endcase
    if (load_fault) WD = '0;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage, using a scoreboard queue of writeback results and
// a cycle model of valid and instret. A second instance with a 4-bit counter exercises wrap-around.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
  logic        RegWrite, wb_valid, load_fault;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic [63:0] instret;
  logic        rw_s, valid_s, fault_s;
  logic [4:0]  wr_s;
  logic [31:0] wd_s;
  logic [3:0]  instret_s;

  logic [38:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;
  logic [63:0] m_cnt   = '0;
  logic [63:0] base;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .CNT_W(64)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
    .RegWrite(RegWrite), .WR(WR), .WD(WD), .wb_valid(wb_valid), .load_fault(load_fault),
    .instret(instret)
  );

  writeback_stage #(.XLEN(32), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
    .RegWrite(rw_s), .WR(wr_s), .WD(wd_s), .wb_valid(valid_s), .load_fault(fault_s),
    .instret(instret_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_fault(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      3'b010:         return off != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] bsh, hsh;
    bsh = w >> (off * 8);
    hsh = w >> (off[1] * 16);
    case (f3)
      3'b000:  return {{24{bsh[7]}}, bsh[7:0]};
      3'b100:  return {24'h0, bsh[7:0]};
      3'b001:  return {{16{hsh[15]}}, hsh[15:0]};
      3'b101:  return {16'h0, hsh[15:0]};
      default: return w;
    endcase
  endfunction

  // Advance one clock, updating the bench's own view of valid/fault/count from the driven inputs.
  task automatic tick();
    if (rst) begin
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      if (m_valid && !m_fault && (!stall || flush)) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (!stall) begin
        m_valid = in_valid;
        m_fault = in_valid && (in_wb_sel == 2'b01) && ref_fault(in_funct3, in_alu_result[1:0]);
      end
    end
    @(posedge clk);
    #1;
    check("wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
    check("instret", instret, m_cnt);
    check("instret_small", {60'd0, instret_s}, {60'd0, m_cnt[3:0]});
  endtask

  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                      input logic [31:0] pc);
    logic        fl;
    logic [31:0] wd;
    logic [38:0] e;
    in_valid = 1'b1; in_reg_write = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
    in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc;
    stall = 1'b0; flush = 1'b0;
    fl = (sel == 2'b01) && ref_fault(f3, alu[1:0]);
    if (fl)                wd = 32'h0;
    else if (sel == 2'b01) wd = ref_load(rdata, alu[1:0], f3);
    else if (sel == 2'b10) wd = pc;
    else                   wd = alu;
    exp_q.push_back({rw && (rd != 5'd0) && !fl, rd, wd, fl});
    tick();
    e = exp_q.pop_front();
    check("regwrite", {63'd0, RegWrite}, {63'd0, e[38]});
    check("wr", {59'd0, WR}, {59'd0, e[37:33]});
    check("wd", {32'd0, WD}, {32'd0, e[32:1]});
    check("load_fault", {63'd0, load_fault}, {63'd0, e[0]});
  endtask

  task automatic idle();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
    in_rd = '0; in_wb_sel = '0; in_funct3 = '0;
    in_alu_result = '0; in_mem_rdata = '0; in_pc_plus4 = '0;
    tick();
    tick();
    check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    check("rst_wr", {59'd0, WR}, 64'd0);
    check("rst_wd", {32'd0, WD}, 64'd0);
    check("rst_fault", {63'd0, load_fault}, 64'd0);
    check("rst_instret", instret, 64'd0);
    rst = 1'b0;

    send(1'b1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
    check("alu_wd", {32'd0, WD}, 64'h1234_5678);
    idle();
    check("alu_retire", instret, 64'd1);

    send(1'b1, 5'd3, 2'b01, 3'b000, 32'h1000_0003, 32'h80FF_7F01, 32'h0);
    check("lb_wd", {32'd0, WD}, 64'hFFFF_FF80);
    send(1'b1, 5'd3, 2'b01, 3'b100, 32'h1000_0003, 32'h80FF_7F01, 32'h0);
    check("lbu_wd", {32'd0, WD}, 64'h0000_0080);
    send(1'b1, 5'd3, 2'b01, 3'b101, 32'h1000_0002, 32'h80FF_7F01, 32'h0);
    check("lhu_wd", {32'd0, WD}, 64'h0000_80FF);

    base = m_cnt;
    send(1'b1, 5'd4, 2'b01, 3'b010, 32'h1000_0002, 32'h80FF_7F01, 32'h0);
    check("lw_mis_fault", {63'd0, load_fault}, 64'd1);
    check("lw_mis_wd", {32'd0, WD}, 64'd0);
    idle();
    check("lw_mis_nocount", instret, base + 64'd1);

    base = m_cnt;
    send(1'b1, 5'd0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
    check("rd0_regwrite", {63'd0, RegWrite}, 64'd0);
    idle();
    check("rd0_count", instret, base + 64'd1);

    send(1'b1, 5'd9, 2'b10, 3'b000, 32'h5555_0000, 32'h0, 32'h0000_2004);
    check("pc4_wd", {32'd0, WD}, 64'h0000_2004);
    send(1'b1, 5'd10, 2'b11, 3'b001, 32'hA5A5_0001, 32'hFFFF_FFFF, 32'h4);
    check("rsvd_wd", {32'd0, WD}, 64'hA5A5_0001);
    send(1'b1, 5'd11, 2'b01, 3'b011, 32'h0, 32'h1234_5678, 32'h0);
    check("f3_011_fault", {63'd0, load_fault}, 64'd1);
    idle();

    // Held instruction under a 3-cycle stall while new (ignored) inputs are presented.
    base = m_cnt;
    send(1'b1, 5'd7, 2'b00, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0);
    stall = 1'b1; in_valid = 1'b1; in_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      in_alu_result = $urandom();
      tick();
      check("stall_regwrite", {63'd0, RegWrite}, 64'd1);
      check("stall_wr", {59'd0, WR}, 64'd7);
      check("stall_wd", {32'd0, WD}, 64'hCAFE_F00D);
    end
    check("stall_nocount", instret, base);
    idle();
    check("stall_count_once", instret, base + 64'd1);

    send(1'b1, 5'd8, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_stall_valid", {63'd0, wb_valid}, 64'd0);
    check("flush_stall_rw", {63'd0, RegWrite}, 64'd0);

    send(1'b1, 5'd6, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0);
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_stall_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_stall_instret", instret, 64'd0);
    rst = 1'b0; stall = 1'b0;

    for (int i = 0; i < 16; i++)
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 1)) << 1,
           3'b000, $urandom(), $urandom(), $urandom());
    idle();
    check("retire16", instret, 64'd16);
    check("small_wrap", {60'd0, instret_s}, 64'd0);

    for (int i = 0; i < 24; i++)
      send(1'b1, 5'($urandom_range(1, 31)), 2'b01, 3'($urandom_range(0, 7)),
           $urandom(), $urandom(), $urandom());
    idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32, data path width.
REQ-002 Parameter CNT_W, default 64, retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 stall  input  1  hold stage contents.
REQ-006 flush  input  1  kill incoming instruction.
REQ-007 in_valid  input  1  MEM-stage instruction valid.
REQ-008 in_reg_write  input  1  instruction writes rd.
REQ-009 in_rd  input  5  destination register.
REQ-010 in_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-011 in_funct3  input  3  load width/sign code.
REQ-012 in_alu_result  input  XLEN  ALU result; load effective address when in_wb_sel=01.
REQ-013 in_mem_rdata  input  XLEN  raw aligned data-memory word.
REQ-014 in_pc_plus4  input  XLEN  link value.
REQ-015 RegWrite  output  1  register-file write enable.
REQ-016 WR  output  5  register-file write address.
REQ-017 WD  output  XLEN  register-file write data.
REQ-018 wb_valid  output  1  stage holds a valid instruction.
REQ-019 load_fault  output  1  held load is misaligned or has an illegal funct3.
REQ-020 instret  output  CNT_W  retired-instruction count.

Function
REQ-021 At posedge clk, priority SHALL be rst > flush > stall > capture.
REQ-022 On flush, wb_valid SHALL become 0 and other held fields are don't-care.
REQ-023 On stall without flush, all held fields and instret-relevant state SHALL hold.
REQ-024 On capture, all in_* fields SHALL be registered and wb_valid set to in_valid; latency is one cycle from input to RegWrite/WR/WD.
REQ-025 RegWrite SHALL be combinational from held state: wb_valid & reg_write & (rd!=0) & !load_fault.
REQ-026 WR SHALL equal held rd.
REQ-027 WD SHALL select as follows: wb_sel=00 or 11 gives alu_result; 01 gives extended load data; 10 gives pc_plus4.
REQ-028 Load extraction SHALL use offset = alu_result[1:0].
REQ-029 funct3 000 (LB) and 100 (LBU) SHALL take byte[offset], sign-extended and zero-extended respectively.
REQ-030 funct3 001 (LH) and 101 (LHU) SHALL take halfword[offset[1]], sign-extended and zero-extended respectively.
REQ-031 funct3 010 (LW) SHALL take the whole word.
REQ-032 load_fault SHALL be 1 iff wb_valid & wb_sel=01 and any of the following holds: LH/LHU with offset[0]=1; LW with offset!=0; funct3 in {011,110,111}.
REQ-033 When load_fault=1, WD SHALL be 0.
REQ-034 instret SHALL increment by 1 at any posedge where wb_valid=1, load_fault=0, rst=0, and (stall=0 or flush=1); it wraps from all-ones to 0.
REQ-035 A stalled valid instruction SHALL keep RegWrite asserted each cycle with unchanged WR/WD and SHALL be counted exactly once.

Reset
REQ-036 While rst is sampled high: wb_valid=0, all held fields=0, instret=0; hence RegWrite=0, WR=0, WD=0, load_fault=0 from the next cycle.
REQ-037 rst mid-stall or mid-flush SHALL discard the held instruction without counting it.

Structure
REQ-038 Package riscv_pkg SHALL hold the WB_SEL_* encodings, LOAD_F3_* funct3 constants and XLEN.
REQ-039 One combinational sub-module, load_extend (inputs raw word, offset, funct3; outputs data and fault), SHALL implement REQ-028..REQ-033.

Verification
REQ-040 Capture with rd=5, wb_sel=00, alu=0x1234_5678 -> next cycle RegWrite=1, WR=5, WD=0x1234_5678, instret +1 on the following edge.
REQ-041 LB with rdata=0x80FF_7F01, offset=3 -> WD=0xFFFF_FF80; the same with LBU -> WD=0x0000_0080; LHU with offset=2 -> WD=0x0000_80FF.
REQ-042 LW with offset=2 -> load_fault=1, RegWrite=0, WD=0, instret unchanged.
REQ-043 Capture with rd=0, reg_write=1 -> RegWrite=0; instret still +1.
REQ-044 Valid instruction held by stall for 3 cycles -> RegWrite=1 all 3 cycles, instret +1 total; flush and stall together -> wb_valid=0 next cycle.
REQ-045 instret preloaded to 0xFFFF_FFFF_FFFF_FFFF then one retire -> 0; rst during stall -> wb_valid=0, instret=0 next cycle.
